lsu_mem_seq: RTL

Multi-cycle load/store sequencer driven by the decoder's memory controls: mem_wren, i_data_type and i_unsigned, with the ALU-computed address. It executes one core memory operation against a word-wide memory with a req/ack handshake. It splits accesses that cross a word boundary into two word accesses, applies byte-lane masks, and returns sign- or zero-extended load data. While the operation is in flight it stalls the core.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_lane_align.sv | 59 +++++
 rtl/lsu_mem_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store sequencer.
//   - data-type encodings used by the decoder (i_data_type)
//   - FSM state encoding for the sequencer
//   - the latched description of one core memory operation
//   - size_bytes(): access size in bytes for a data type
package lsu_pkg;

   localparam logic [1:0] DT_WORD = 2'b00;
   localparam logic [1:0] DT_HALF = 2'b01;
   localparam logic [1:0] DT_BYTE = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      ACC1 = 2'd2,
      DONE = 2'd3
   } lsu_state_e;

   // One core memory operation as presented by the decoder/ALU.
   typedef struct packed {
      logic        wren;
      logic [31:0] addr;
      logic [31:0] st_data;
      logic [1:0]  dtype;
      logic        uns;
   } lsu_op_t;

   // The reserved encoding 2'b11 behaves as a word.
   function automatic logic [2:0] size_bytes(input logic [1:0] dtype);
      case (dtype)
         DT_HALF: return 3'd2;
         DT_BYTE: return 3'd1;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: purely combinational byte-lane steering.
//   Store side: shifts the store data and the byte-enable mask into a
//   64-bit window spanning two consecutive words; the low half feeds the
//   first word access, the high half the second.
//   Load side: shifts the {hi,lo} word pair right by the byte offset and
//   sign- or zero-extends the addressed halfword/byte.
// Ports:
//   off_i      byte offset within the word (addr[1:0])
//   dtype_i    data type (word/half/byte, 2'b11 = word)
//   uns_i      zero-extend loads when 1
//   st_data_i  store data, right-aligned
//   lo_i/hi_i  read words of the first / second access
//   wdata0_o, bmask0_o  lanes for the first word access
//   wdata1_o, bmask1_o  lanes for the second word access
//   ld_data_o  extended load result
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  off_i,
   input  logic [1:0]  dtype_i,
   input  logic        uns_i,
   input  logic [31:0] st_data_i,
   input  logic [31:0] lo_i,
   input  logic [31:0] hi_i,
   output logic [31:0] wdata0_o,
   output logic [31:0] wdata1_o,
   output logic [3:0]  bmask0_o,
   output logic [3:0]  bmask1_o,
   output logic [31:0] ld_data_o
);

   logic [2:0]  n_bytes;
   logic [5:0]  shamt;
   logic [63:0] s64;
   logic [7:0]  m8;
   logic [63:0] r64;
   logic        sign_b;
   logic        sign_h;

   assign n_bytes = size_bytes(dtype_i);
   assign shamt   = {off_i, 3'b000};

   assign s64 = {32'h0, st_data_i} << shamt;
   assign m8  = 8'((9'd1 << n_bytes) - 9'd1) << off_i;

   assign wdata0_o = s64[31:0];
   assign wdata1_o = s64[63:32];
   assign bmask0_o = m8[3:0];
   assign bmask1_o = m8[7:4];

   assign r64    = {hi_i, lo_i} >> shamt;
   assign sign_b = ~uns_i & r64[7];
   assign sign_h = ~uns_i & r64[15];

   assign ld_data_o = (dtype_i == DT_BYTE) ? {{24{sign_b}}, r64[7:0]}  :
                      (dtype_i == DT_HALF) ? {{16{sign_h}}, r64[15:0]} :
                                             r64[31:0];

endmodule

// File: rtl/lsu_mem_seq.sv
// lsu_mem_seq: multi-cycle load/store sequencer.
//   Executes one core memory operation against a word-wide memory with a
//   req/ack handshake, splitting word-boundary-crossing accesses into two
//   word accesses, and stalls the core while the operation is in flight.
// Ports:
//   i_clk, i_reset          clock, asynchronous active-low reset
//   i_lsu_req               operation request, held until o_done
//   i_lsu_wren              1 = store, 0 = load
//   i_lsu_addr              byte address
//   i_st_data               store data
//   i_data_type, i_unsigned access size and load extension
//   o_ld_data               load result, updated on o_done
//   o_stall                 freeze the core (i_lsu_req & ~o_done)
//   o_done, o_err           completion pulse, timeout flag
//   o_mem_*                 memory request: req, we, word addr, wdata, bmask
//   i_mem_ack, i_mem_rdata  memory response
module lsu_mem_seq
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_lsu_req,
   input  logic        i_lsu_wren,
   input  logic [31:0] i_lsu_addr,
   input  logic [31:0] i_st_data,
   input  logic [1:0]  i_data_type,
   input  logic        i_unsigned,
   output logic [31:0] o_ld_data,
   output logic        o_stall,
   output logic        o_done,
   output logic        o_err,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_bmask,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   lsu_state_e  state_q, state_d;
   lsu_op_t     op_q, op_d;
   logic [31:0] lo_q, lo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_bmask_q, mem_bmask_d;
   logic [31:0] ld_data_q, ld_data_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   lsu_op_t     live_op;
   lsu_op_t     cur_op;
   logic [2:0]  n_bytes;
   logic        split;
   logic [31:0] lo_in, hi_in;
   logic [31:0] wdata0, wdata1, ld_ext;
   logic [3:0]  bmask0, bmask1;
   logic        timeout;
   logic        finish;
   logic        abort;

   // In IDLE the first access is launched straight from the core inputs;
   // afterwards everything works from the latched copy.
   assign live_op = '{wren: i_lsu_wren, addr: i_lsu_addr, st_data: i_st_data,
                      dtype: i_data_type, uns: i_unsigned};
   assign cur_op  = (state_q == IDLE) ? live_op : op_q;

   assign n_bytes = size_bytes(cur_op.dtype);
   assign split   = ({2'b00, cur_op.addr[1:0]} + {1'b0, n_bytes}) > 4'd4;

   // The final ack's read data is used in the same cycle it arrives, so
   // the word being acknowledged bypasses its capture register.
   assign lo_in = (state_q == ACC1) ? lo_q : i_mem_rdata;
   assign hi_in = (state_q == ACC1) ? i_mem_rdata : 32'h0;

   lsu_lane_align u_align (
      .off_i     (cur_op.addr[1:0]),
      .dtype_i   (cur_op.dtype),
      .uns_i     (cur_op.uns),
      .st_data_i (cur_op.st_data),
      .lo_i      (lo_in),
      .hi_i      (hi_in),
      .wdata0_o  (wdata0),
      .wdata1_o  (wdata1),
      .bmask0_o  (bmask0),
      .bmask1_o  (bmask1),
      .ld_data_o (ld_ext)
   );

   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   // NOTE: every signal written here gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      lo_d        = lo_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_bmask_d = mem_bmask_q;
      ld_data_d   = ld_data_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      finish      = 1'b0;
      abort       = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_lsu_req) begin
               op_d        = live_op;
               state_d     = ACC0;
               mem_req_d   = 1'b1;
               mem_we_d    = live_op.wren;
               mem_addr_d  = {live_op.addr[31:2], 2'b00};
               mem_wdata_d = wdata0;
               mem_bmask_d = live_op.wren ? bmask0 : 4'hF;
               cnt_d       = '0;
            end
         end
         ACC0: begin
            if (i_mem_ack) begin
               lo_d = i_mem_rdata;
               if (split) begin
                  state_d     = ACC1;
                  mem_addr_d  = mem_addr_q + 32'd4;   // wraps past 0xFFFFFFFC
                  mem_wdata_d = wdata1;
                  mem_bmask_d = op_q.wren ? bmask1 : 4'hF;
                  cnt_d       = '0;
               end else begin
                  finish = 1'b1;
               end
            end else if (timeout) begin
               abort = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ACC1: begin
            if (i_mem_ack) begin
               finish = 1'b1;
            end else if (timeout) begin
               abort = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // An ack on the last allowed cycle still counts as success.
      if (finish || abort) begin
         state_d   = DONE;
         mem_req_d = 1'b0;
         mem_we_d  = 1'b0;
         done_d    = 1'b1;
      end
      if (finish && !op_q.wren) begin
         ld_data_d = ld_ext;
      end
      if (abort) begin
         err_d     = 1'b1;
         ld_data_d = 32'h0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q     <= IDLE;
         op_q        <= '0;
         lo_q        <= '0;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_bmask_q <= '0;
         ld_data_q   <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         lo_q        <= lo_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_bmask_q <= mem_bmask_d;
         ld_data_q   <= ld_data_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign o_mem_req   = mem_req_q;
   assign o_mem_we    = mem_we_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_wdata_q;
   assign o_mem_bmask = mem_bmask_q;
   assign o_ld_data   = ld_data_q;
   assign o_done      = done_q;
   assign o_err       = err_q;
   assign o_stall     = i_lsu_req & ~done_q;

endmodule
